// File: rtl/array_pattern_sink.sv
// array_pattern_sink
//   Receiving end for a block that drives a constant multi-bit word. Each
//   word accepted over the valid/ready handshake is compared against
//   EXPECTED. After LOCK_COUNT consecutive matches the sink reports lock.
//   Any mismatch after lock parks the sink in ERROR until clear or reset.
//   Saturating match/mismatch counters are kept for debug visibility.
//
// Ports
//   CLK            rising-edge clock
//   ASYNCRESETN    asynchronous active-low reset
//   I / I_valid    incoming word and its valid strobe
//   I_ready        sink can accept (low only in ERROR)
//   clear          synchronous clear of state, O, counters and error
//   O              last accepted word (registered)
//   locked         high while in LOCKED
//   error          sticky mismatch-after-lock flag
//   match_count    accepted words equal to EXPECTED (saturating)
//   mismatch_count accepted words not equal to EXPECTED (saturating)
module array_pattern_sink #(
   parameter int                WIDTH      = 2,
   parameter logic [WIDTH-1:0]  EXPECTED   = 2'b11,
   parameter int                LOCK_COUNT = 4,
   parameter int                CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [WIDTH-1:0] I,
   input  logic             I_valid,
   output logic             I_ready,
   input  logic             clear,
   output logic [WIDTH-1:0] O,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] mismatch_count
);

   localparam int                RUN_W    = $clog2(LOCK_COUNT + 1);
   localparam logic [RUN_W-1:0]  LOCK_RUN = RUN_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SYNC, LOCKED, ERROR} state_t;

   state_t           state, state_nxt;
   logic [RUN_W-1:0] run, run_nxt, run_inc;
   logic             accept, hit;

   // Ready depends on state only, never on I_valid.
   assign I_ready = (state != ERROR);
   assign locked  = (state == LOCKED);
   assign error   = (state == ERROR);
   assign accept  = I_valid & I_ready;
   assign hit     = (I == EXPECTED);
   assign run_inc = run + RUN_W'(1);

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= IDLE;
         run   <= '0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      if (clear) begin
         // clear wins over a simultaneous handshake; that word is dropped
         state_nxt = IDLE;
         run_nxt   = '0;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (hit) begin
                  if (LOCK_COUNT == 1) begin
                     state_nxt = LOCKED;
                     run_nxt   = LOCK_RUN;
                  end else begin
                     state_nxt = SYNC;
                     run_nxt   = RUN_W'(1);
                  end
               end else begin
                  run_nxt = '0;
               end
            end
            SYNC: begin
               if (hit) begin
                  run_nxt = run_inc;
                  if (run_inc == LOCK_RUN) state_nxt = LOCKED;
               end else begin
                  state_nxt = IDLE;
                  run_nxt   = '0;
               end
            end
            LOCKED: begin
               if (!hit) state_nxt = ERROR;
            end
            default: ;
         endcase
      end
   end

   // Datapath: captured word and saturating counters.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         O              <= '0;
         match_count    <= '0;
         mismatch_count <= '0;
      end else if (clear) begin
         O              <= '0;
         match_count    <= '0;
         mismatch_count <= '0;
      end else if (accept) begin
         O <= I;
         if (hit) begin
            if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
         end else begin
            if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_W'(1);
         end
      end
   end

endmodule
